banco_biquad_tdm: RTL and testbench

Time-multiplexed IIR equaliser filter bank: one shared multiply-accumulate unit evaluates BANDS parallel bands, each a cascade of STAGES direct-form-I biquad sections, once per input audio sample. Coefficients are runtime-loadable through a write port, so band edges change without resynthesis. Sits between the audio sample source and the per-band gain/mixing stage of the equaliser, and generalises the fixed three-band, two-section, fully parallel bank.

---
 rtl/banco_pkg.sv | 38 +++
 rtl/banco_biquad_tdm_mac.sv | 47 ++++
 rtl/banco_biquad_tdm.sv | 219 +++++++++++++++++++++
 tb/tb_banco_biquad_tdm.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/banco_pkg.sv
// Shared constants, FSM state encoding and saturation helper
// for the time-multiplexed biquad equaliser bank.
package banco_pkg;

  localparam int K_B0 = 0;
  localparam int K_B1 = 1;
  localparam int K_B2 = 2;
  localparam int K_A1 = 3;
  localparam int K_A2 = 4;
  localparam int NCOEF = 5;

  // Guard bits above the 2N-bit product: five terms per section
  localparam int ACC_GUARD = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MAC   = 3'd2,
    STORE = 3'd3,
    MIX   = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Clamp to an n-bit signed range; caller truncates to n bits
  function automatic logic signed [63:0] sat(
    input logic signed [63:0] v,
    input int n
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (n - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/banco_biquad_tdm_mac.sv
// Shared signed multiply-accumulate with add/subtract control
// and a shift-and-saturate view of the running sum.
module biquad_mac
  import banco_pkg::*;
#(
  parameter int N     = 23,
  parameter int DECIM = 14
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clr,
  input  logic                en,
  input  logic                sub,
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic signed [N-1:0] y
);

  localparam int ACC_W = 2 * N + ACC_GUARD;

  logic signed [2*N-1:0]   prod;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shr;

  // y reflects the sum including this cycle's product,
  // so the final product is visible without an extra cycle
  always_comb begin
    prod = a * b;
    term = en ? ACC_W'(prod) : '0;
    sum  = sub ? acc - term : acc + term;
    shr  = sum >>> DECIM;
    y    = N'(sat(64'(shr), N));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/banco_biquad_tdm.sv
// TDM IIR filter bank: BANDS x STAGES DF-I biquads on one MAC.
// Define BANCO_GAIN_EN to add per-band gain and a mixed output.
module banco_biquad_tdm
  import banco_pkg::*;
#(
  parameter int N      = 23,
  parameter int DECIM  = 14,
  parameter int BANDS  = 3,
  parameter int STAGES = 2,
  localparam int AW    = $clog2(BANDS * STAGES * NCOEF)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sample_valid,
  input  logic signed [N-1:0]   sample_in,
  input  logic                  coef_we,
  input  logic [AW-1:0]         coef_addr,
  input  logic signed [N-1:0]   coef_data,
`ifdef BANCO_GAIN_EN
  input  logic [BANDS*N-1:0]    gain_in,
  output logic signed [N-1:0]   mix_out,
`endif
  output logic                  coef_rdy,
  output logic                  busy,
  output logic [BANDS*N-1:0]    band_out,
  output logic                  out_valid,
  output logic                  overrun
);

  localparam int NS = BANDS * STAGES;
  localparam int NC = NS * NCOEF;
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;
  localparam int BW = (BANDS > 1) ? $clog2(BANDS) : 1;
  localparam int TW = (STAGES > 1) ? $clog2(STAGES) : 1;

  state_t state;

  logic [2:0]    k_q;
  logic [SW-1:0] sec_q;
  logic [BW-1:0] band_q;
  logic [TW-1:0] stg_q;
  logic [AW-1:0] cbase_q;
  logic [AW-1:0] cidx;

  logic signed [N-1:0] samp_q;
  logic signed [N-1:0] coef [NC];
  logic signed [N-1:0] x1 [NS];
  logic signed [N-1:0] x2 [NS];
  logic signed [N-1:0] y1 [NS];
  logic signed [N-1:0] y2 [NS];
  logic signed [N-1:0] bo [BANDS];
`ifdef BANCO_GAIN_EN
  logic signed [N-1:0] gain_q [BANDS];
`endif

  logic signed [N-1:0] xin;
  logic signed [N-1:0] op_a;
  logic signed [N-1:0] op_b;
  logic signed [N-1:0] mac_y;
  logic mac_en;
  logic mac_clr;
  logic mac_sub;
  logic last_stg;
  logic last_sec;

  assign busy      = (state != IDLE) && (state != DONE);
  assign coef_rdy  = !busy;
  assign out_valid = (state == DONE);
  assign last_stg  = (stg_q == TW'(STAGES - 1));
  assign last_sec  = (sec_q == SW'(NS - 1));
  assign cidx      = cbase_q + AW'(k_q);

  for (genvar b = 0; b < BANDS; b++) begin : g_out
    assign band_out[b*N +: N] = bo[b];
  end

  // Later stages read the previous section's freshly stored y1
  always_comb begin
    xin = (stg_q == '0) ? samp_q : y1[sec_q - SW'(1)];
    op_a = coef[cidx];
    unique case (k_q)
      3'(K_B0): op_b = xin;
      3'(K_B1): op_b = x1[sec_q];
      3'(K_B2): op_b = x2[sec_q];
      3'(K_A1): op_b = y1[sec_q];
      3'(K_A2): op_b = y2[sec_q];
      default:  op_b = xin;
    endcase
    mac_sub = (k_q >= 3'(K_A1)) && (state == MAC);
    mac_en  = (state == MAC);
    mac_clr = (state == LOAD);
`ifdef BANCO_GAIN_EN
    if (state == MIX) begin
      op_a   = bo[band_q];
      op_b   = gain_q[band_q];
      mac_en = 1'b1;
    end
    if (state == STORE && last_sec) mac_clr = 1'b1;
`endif
  end

  biquad_mac #(
    .N     (N),
    .DECIM (DECIM)
  ) u_mac (
    .clock (clock),
    .reset (reset),
    .clr   (mac_clr),
    .en    (mac_en),
    .sub   (mac_sub),
    .a     (op_a),
    .b     (op_b),
    .y     (mac_y)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      k_q     <= '0;
      sec_q   <= '0;
      band_q  <= '0;
      stg_q   <= '0;
      cbase_q <= '0;
      samp_q  <= '0;
      overrun <= 1'b0;
      for (int b = 0; b < BANDS; b++) bo[b] <= '0;
`ifdef BANCO_GAIN_EN
      mix_out <= '0;
      for (int b = 0; b < BANDS; b++) gain_q[b] <= '0;
`endif
    end else begin
      if (sample_valid && state != IDLE) overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (sample_valid) begin
            samp_q  <= sample_in;
            k_q     <= '0;
            sec_q   <= '0;
            band_q  <= '0;
            stg_q   <= '0;
            cbase_q <= '0;
`ifdef BANCO_GAIN_EN
            for (int b = 0; b < BANDS; b++)
              gain_q[b] <= gain_in[b*N +: N];
`endif
            state <= LOAD;
          end
        end
        LOAD: begin
          k_q   <= '0;
          state <= MAC;
        end
        MAC: begin
          k_q <= k_q + 3'd1;
          if (k_q == 3'(K_A2)) state <= STORE;
        end
        STORE: begin
          if (last_stg) bo[band_q] <= mac_y;
          sec_q   <= sec_q + SW'(1);
          cbase_q <= cbase_q + AW'(NCOEF);
          if (last_stg) begin
            stg_q  <= '0;
            band_q <= band_q + BW'(1);
          end else begin
            stg_q <= stg_q + TW'(1);
          end
          if (!last_sec) begin
            state <= LOAD;
          end else begin
`ifdef BANCO_GAIN_EN
            band_q <= '0;
            state  <= MIX;
`else
            state  <= DONE;
`endif
          end
        end
`ifdef BANCO_GAIN_EN
        MIX: begin
          band_q <= band_q + BW'(1);
          if (band_q == BW'(BANDS - 1)) begin
            mix_out <= mac_y;
            state   <= DONE;
          end
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NS; i++) begin
        x1[i] <= '0;
        x2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
    end else if (state == STORE) begin
      x2[sec_q] <= x1[sec_q];
      x1[sec_q] <= xin;
      y2[sec_q] <= y1[sec_q];
      y1[sec_q] <= mac_y;
    end
  end

  // Reset coefficients make every section a unity passthrough
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NC; i++)
        coef[i] <= (i % NCOEF == K_B0) ? N'(1 << DECIM) : '0;
    end else if (coef_we && !busy && coef_addr < AW'(NC)) begin
      coef[coef_addr] <= coef_data;
    end
  end

endmodule

// File: tb/tb_banco_biquad_tdm.sv
// Self-checking bench for banco_biquad_tdm: vector table,
// scoreboard queue and multi-cycle corner sequences.
module tb_banco_biquad_tdm;

  localparam int N     = 23;
  localparam int BANDS = 3;
  localparam int AW    = 5;
  localparam int NV    = 15;
`ifdef BANCO_GAIN_EN
  localparam int LAT = 46;
`else
  localparam int LAT = 43;
`endif

  logic clock = 1'b0;
  logic reset;
  logic sample_valid;
  logic signed [N-1:0] sample_in;
  logic coef_we;
  logic [AW-1:0] coef_addr;
  logic signed [N-1:0] coef_data;
  logic coef_rdy;
  logic busy;
  logic [BANDS*N-1:0] band_out;
  logic out_valid;
  logic overrun;
`ifdef BANCO_GAIN_EN
  logic [BANDS*N-1:0] gain_in;
  logic signed [N-1:0] mix_out;
  assign gain_in = {23'd0, 23'd8192, 23'd16384};
`endif

  banco_biquad_tdm dut (
    .clock        (clock),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
`ifdef BANCO_GAIN_EN
    .gain_in      (gain_in),
    .mix_out      (mix_out),
`endif
    .coef_rdy     (coef_rdy),
    .busy         (busy),
    .band_out     (band_out),
    .out_valid    (out_valid),
    .overrun      (overrun)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [BANDS*N-1:0]  bo;
    logic signed [N-1:0] mix;
  } exp_t;

  typedef struct {
    bit                  rst;
    bit                  wr;
    logic [AW-1:0]       wa;
    logic signed [N-1:0] wd;
    logic signed [N-1:0] x;
    logic signed [N-1:0] e0;
    logic signed [N-1:0] e1;
    logic signed [N-1:0] e2;
  } vec_t;

  exp_t q[$];
  exp_t mon_e;
  vec_t vecs[NV];

  task automatic check(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic vec_t mk(bit rst, bit wr, int wa, int wd,
                              int x, int e0, int e1, int e2);
    vec_t v;
    v.rst = rst;
    v.wr  = wr;
    v.wa  = AW'(wa);
    v.wd  = N'(wd);
    v.x   = N'(x);
    v.e0  = N'(e0);
    v.e1  = N'(e1);
    v.e2  = N'(e2);
    return v;
  endfunction

  // Gains 1.0 / 0.5 / 0 applied to the band results
  function automatic logic signed [N-1:0] mixf(
    logic signed [N-1:0] e0, logic signed [N-1:0] e1,
    logic signed [N-1:0] e2);
    longint s;
    s = (longint'(e0) * 16384 + longint'(e1) * 8192
         + longint'(e2) * 0) >>> 14;
    if (s > 4194303) s = 4194303;
    if (s < -4194304) s = -4194304;
    return N'(s);
  endfunction

  always @(posedge clock) begin
    #1;
    if (out_valid) begin
      if (q.size() == 0) begin
        check("spurious_out_valid", out_valid, 0);
      end else begin
        mon_e = q.pop_front();
        for (int b = 0; b < BANDS; b++)
          check($sformatf("band%0d", b),
                $signed(band_out[b*N +: N]),
                $signed(mon_e.bo[b*N +: N]));
`ifdef BANCO_GAIN_EN
        check("mix_out", mix_out, mon_e.mix);
`endif
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    sample_valid = 1'b0;
    coef_we = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    q.delete();
  endtask

  task automatic check_reset_outs();
    for (int b = 0; b < BANDS; b++)
      check("rst_band_out", $signed(band_out[b*N +: N]), 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_coef_rdy", coef_rdy, 1);
`ifdef BANCO_GAIN_EN
    check("rst_mix_out", mix_out, 0);
`endif
  endtask

  task automatic wr_coef(input logic [AW-1:0] a,
                         input logic signed [N-1:0] d);
    @(posedge clock);
    #1;
    coef_we = 1'b1;
    coef_addr = a;
    coef_data = d;
    check("coef_rdy_idle", coef_rdy, 1);
    @(posedge clock);
    #1;
    coef_we = 1'b0;
  endtask

  task automatic start(input logic signed [N-1:0] x,
                       input logic signed [N-1:0] e0,
                       input logic signed [N-1:0] e1,
                       input logic signed [N-1:0] e2);
    exp_t e;
    @(posedge clock);
    #1;
    sample_valid = 1'b1;
    sample_in = x;
    e.bo = {e2, e1, e0};
    e.mix = mixf(e0, e1, e2);
    q.push_back(e);
    @(posedge clock);
    #1;
    sample_valid = 1'b0;
    check("busy_after_accept", busy, 1);
  endtask

  task automatic wait_done(input int n0);
    int n;
    n = n0;
    while (!out_valid && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("latency", n, LAT);
    check("busy_at_done", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    sample_valid = 1'b0;
    sample_in = '0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_data = '0;

    vecs[0]  = mk(1, 0, 0, 0, 1000, 1000, 1000, 1000);
    vecs[1]  = mk(0, 0, 0, 0, 4000, 4000, 4000, 4000);
    vecs[2]  = mk(0, 0, 0, 0, -1000, -1000, -1000, -1000);
    vecs[3]  = mk(0, 0, 0, 0, 4194303, 4194303, 4194303, 4194303);
    vecs[4]  = mk(0, 0, 0, 0, -4194304, -4194304, -4194304, -4194304);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 1, 0, 8192, 8192, 4096, 8192, 8192);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 100, 50, 100, 100);
    vecs[9]  = mk(0, 0, 0, 0, -3, -2, -3, -3);
    vecs[10] = mk(1, 1, 3, -16384, 4194303, 4194303, 4194303, 4194303);
    vecs[11] = mk(0, 0, 0, 0, 4194303, 4194303, 4194303, 4194303);
    vecs[12] = mk(0, 0, 0, 0, 4194303, 4194303, 4194303, 4194303);
    vecs[13] = mk(0, 0, 0, 0, -4194304, -1, -4194304, -4194304);
    vecs[14] = mk(0, 0, 0, 0, -4194304, -4194304, -4194304, -4194304);

    do_reset();
    check_reset_outs();

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rst) do_reset();
      if (vecs[i].wr) wr_coef(vecs[i].wa, vecs[i].wd);
      start(vecs[i].x, vecs[i].e0, vecs[i].e1, vecs[i].e2);
      wait_done(1);
    end

    // sample arriving in the DONE cycle is dropped
    do_reset();
    start(1234, 1234, 1234, 1234);
    wait_done(1);
    sample_valid = 1'b1;
    sample_in = 99;
    @(posedge clock);
    #1;
    sample_valid = 1'b0;
    check("overrun_done", overrun, 1);
    repeat (60) @(posedge clock);
    #1;
    start(-77, -77, -77, -77);
    wait_done(1);

    // sample and coefficient write while busy are both ignored
    do_reset();
    start(500, 500, 500, 500);
    repeat (9) @(posedge clock);
    #1;
    sample_valid = 1'b1;
    sample_in = 777;
    coef_we = 1'b1;
    coef_addr = 5'd10;
    coef_data = '0;
    check("coef_rdy_busy", coef_rdy, 0);
    @(posedge clock);
    #1;
    sample_valid = 1'b0;
    coef_we = 1'b0;
    check("overrun_busy", overrun, 1);
    wait_done(11);
    repeat (60) @(posedge clock);
    #1;
    check("overrun_sticky", overrun, 1);
    start(200, 200, 200, 200);
    wait_done(1);

    // reset mid-computation aborts without out_valid
    do_reset();
    start(300, 300, 300, 300);
    repeat (19) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    q.delete();
    check_reset_outs();
    repeat (60) @(posedge clock);
    #1;
    start(300, 300, 300, 300);
    wait_done(1);

    @(posedge clock);
    #1;
    check("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
